mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Main control state machine for the multi-cycle MIPS datapath. It sequences the shared ALU, register file, memory port and PC across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK cycles. It drives the ALU operand selects and 4-bit operation code every cycle and consumes the ALU zero flag for branches. It sits between the instruction register (opcode/funct) and all datapath enables.

## Interface
- `WIDTH`, default 32: instruction-retire counter width.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from end of FETCH until next FETCH.
- `funct` in 6: IR[5:0].
- `zero_flag` in 1: combinational ALU zero, valid in the same cycle as the SUB it reflects.
- `mem_ready` in 1: memory completes the access requested this cycle.
- `pc_en` out 1: PC load = pc_write | (pc_write_cond & zero_flag).
- `pc_source` out 2: 00 ALU result, 01 ALU_out register, 10 jump target.
- `iord` out 1: 0 address = PC, 1 address = ALU_out.
- `mem_read`, `mem_write`, `ir_write` out 1 each.
- `reg_dst` out 1: 0 rt, 1 rd.
- `mem_to_reg` out 1.
- `reg_write` out 1.
- `alu_src_a` out 1: 0 PC, 1 reg_A.
- `alu_src_b` out 2: 00 reg_B, 01 constant 1, 10 sign-extended immediate, 11 immediate<<2.
- `alu_operation` out 4: 0010 add, 0110 sub, 0000 mul, 0011 not.
- `illegal_op` out 1: one-cycle pulse in DECODE on an unsupported opcode/funct.
- `retired` out WIDTH: count of completed instructions.
- `state` out 4: current state, for debug.

## Operation
- Outputs are Moore, decoded from the state register; the only Mealy term is `pc_en` through `zero_flag`.
- While `reset` is high: state = FETCH, `retired` = 0, and all enables are forced to 0 (pc_en, mem_read, mem_write, ir_write, reg_write). Selects are 0 and `alu_operation` = 0010.
- Unlisted outputs are 0 in every state.
- FETCH (0): mem_read, iord=0, alu_src_a=0, alu_src_b=01, add. When mem_ready: ir_write, pc_write, pc_source=00, go to DECODE. Otherwise hold, with no PC or IR write.
- DECODE (1): alu_src_a=0, alu_src_b=11, add (branch target into ALU_out). Next state by opcode:
  - 100011 or 101011 → MEM_ADDR
  - 000000 → R_EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - anything else → FETCH, with illegal_op.
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, add. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (3): mem_read, iord=1. Hold until mem_ready, then MEM_WB.
- MEM_WB (4): reg_write, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WRITE (5): mem_write, iord=1. Hold until mem_ready, then FETCH.
- R_EXEC (6): alu_src_a=1, alu_src_b=00, operation from funct:
  - 100000 → 0010
  - 100010 → 0110
  - 011000 → 0000
  - 100111 → 0011
  - Any other funct pulses illegal_op and returns to FETCH without write-back; this check is made in DECODE.
- R_WB (7): reg_write, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, sub, pc_write_cond, pc_source=01. Then FETCH.
- JUMP (9): pc_write, pc_source=10. Then FETCH.
- ADDI_EXEC (10): alu_src_a=1, alu_src_b=10, add. Then ADDI_WB.
- ADDI_WB (11): reg_write, reg_dst=0, mem_to_reg=0. Then FETCH.
- Encodings 12–15 are unreachable and recover to FETCH.
- `retired` increments on the last cycle of each legal instruction: MEM_WB, MEM_WRITE with mem_ready, R_WB, BRANCH, JUMP, ADDI_WB. It wraps modulo 2^WIDTH.

## Timing
- With mem_ready tied high, cycles per instruction are: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. All outputs hold steady while stalled.
- pc_en in BRANCH follows zero_flag in the same cycle; no registered flag is used.
- Reset asserted mid-instruction aborts it immediately: no partial reg_write, and the retired count is not incremented. The first FETCH begins on the first rising edge after deassertion.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum (4-bit, values above);
  - opcode and funct constants;
  - ALU operation codes (ADD, SUB, MUL, NOT);
  - ALU_SRC_B encodings;
  - PC_SOURCE encodings.
- Sub-module `alu_op_decoder` is combinational: funct → {alu_operation, legal}. It is shared by R_EXEC output decode and the DECODE legality check.

## Test plan
- Reset pulse mid-MEM_READ → state=0, all enables 0, retired=0. After release, FETCH asserts mem_read=1, alu_src_b=01, alu_operation=0010.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0 over 5 cycles. reg_write=1 only in cycle 5 with mem_to_reg=1; retired +1.
- R-type sub (funct 100010) → R_EXEC drives alu_operation=0110, alu_src_a=1, alu_src_b=00. R_WB asserts reg_write with reg_dst=1.
- beq with zero_flag=1 → pc_en=1 in BRANCH with pc_source=01. With zero_flag=0 → pc_en=0. Both take 3 cycles.
- mem_ready held low 3 cycles in FETCH → FETCH lasts 4 cycles; ir_write and pc_en pulse once, only in the final cycle.
- Opcode 111111 → illegal_op pulses in DECODE, next state FETCH, retired unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM:
// state enum, instruction field constants, ALU op codes and mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_NOT = 6'b100111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0000;
  localparam logic [3:0] ALU_NOT = 4'b0011;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_ONE    = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_op_decoder.sv
// R-type funct decoder: yields the ALU operation and whether the funct is
// supported. Shared by R_EXEC output decode and the DECODE legality check.
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_operation,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_operation = ALU_ADD;
    legal         = 1'b1;
    case (funct)
      FN_ADD:  alu_operation = ALU_ADD;
      FN_SUB:  alu_operation = ALU_SUB;
      FN_MUL:  alu_operation = ALU_MUL;
      FN_NOT:  alu_operation = ALU_NOT;
      default: legal         = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_operation,
  output logic             illegal_op,
  output logic [WIDTH-1:0] retired,
  output logic [3:0]       state
);

  state_t     state_q, state_d;
  logic       pc_write, pc_write_cond, retire;
  logic [3:0] funct_op;
  logic       funct_legal;

  alu_op_decoder u_alu_op_decoder (
    .funct         (funct),
    .alu_operation (funct_op),
    .legal         (funct_legal)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + WIDTH'(1);
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_SRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_operation = ALU_ADD;
    illegal_op    = 1'b0;
    retire        = 1'b0;

    // Reset holds every enable and select at its default, even though the
    // state register already reads FETCH.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_ONE;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = SRC_B_IMM_SH;
          state_d   = S_FETCH;
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDI_EXEC;
            OP_RTYPE: begin
              if (funct_legal) state_d    = S_R_EXEC;
              else             illegal_op = 1'b1;
            end
            default:      illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_R_EXEC: begin
          alu_src_a     = 1'b1;
          alu_operation = funct_op;
          state_d       = S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_operation = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_SRC_ALU_OUT;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_JUMP;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          state_d   = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Branch resolution uses the live ALU zero flag of this cycle's SUB.
  assign pc_en = pc_write | (pc_write_cond & zero_flag);
  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its
// state sequence with hand-computed expected outputs, stalls and reset abort.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero_flag, mem_ready;
  logic        pc_en, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  pc_source, alu_src_b;
  logic [3:0]  alu_operation, state;
  logic [31:0] retired;

  int n_compared = 0;
  int n_mismatch = 0;

  mc_control_fsm #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .zero_flag     (zero_flag),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_operation (alu_operation),
    .illegal_op    (illegal_op),
    .retired       (retired),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero_flag = 1'b0; mem_ready = 1'b1;
    #12;
    check("rst_state", state, 4'd0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_ir_write", ir_write, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_reg_write", reg_write, 1'b0);
    check("rst_alu_src_b", alu_src_b, 2'b00);
    check("rst_alu_op", alu_operation, 4'b0010);
    check("rst_retired", retired, 32'd0);

    // lw: states 0,1,2,3,4 then back to 0
    reset = 1'b0; opcode = 6'b100011; #1;
    check("lw_fetch_state", state, 4'd0);
    check("lw_fetch_mem_read", mem_read, 1'b1);
    check("lw_fetch_src_b", alu_src_b, 2'b01);
    check("lw_fetch_ir_write", ir_write, 1'b1);
    check("lw_fetch_pc_en", pc_en, 1'b1);
    check("lw_fetch_reg_write", reg_write, 1'b0);
    tick();
    check("lw_decode_state", state, 4'd1);
    check("lw_decode_src_b", alu_src_b, 2'b11);
    check("lw_decode_illegal", illegal_op, 1'b0);
    check("lw_decode_reg_write", reg_write, 1'b0);
    tick();
    check("lw_addr_state", state, 4'd2);
    check("lw_addr_src_a", alu_src_a, 1'b1);
    check("lw_addr_src_b", alu_src_b, 2'b10);
    check("lw_addr_reg_write", reg_write, 1'b0);
    tick();
    check("lw_read_state", state, 4'd3);
    check("lw_read_iord", iord, 1'b1);
    check("lw_read_mem_read", mem_read, 1'b1);
    check("lw_read_reg_write", reg_write, 1'b0);
    tick();
    check("lw_wb_state", state, 4'd4);
    check("lw_wb_reg_write", reg_write, 1'b1);
    check("lw_wb_mem_to_reg", mem_to_reg, 1'b1);
    check("lw_wb_reg_dst", reg_dst, 1'b0);
    check("lw_wb_retired", retired, 32'd0);
    tick();
    check("lw_done_state", state, 4'd0);
    check("lw_done_retired", retired, 32'd1);

    // R-type sub: 0,1,6,7
    opcode = 6'b000000; funct = 6'b100010;
    tick();
    check("sub_decode_state", state, 4'd1);
    check("sub_decode_illegal", illegal_op, 1'b0);
    tick();
    check("sub_exec_state", state, 4'd6);
    check("sub_exec_op", alu_operation, 4'b0110);
    check("sub_exec_src_a", alu_src_a, 1'b1);
    check("sub_exec_src_b", alu_src_b, 2'b00);
    check("sub_exec_reg_write", reg_write, 1'b0);
    tick();
    check("sub_wb_state", state, 4'd7);
    check("sub_wb_reg_write", reg_write, 1'b1);
    check("sub_wb_reg_dst", reg_dst, 1'b1);
    check("sub_wb_mem_to_reg", mem_to_reg, 1'b0);
    tick();
    check("sub_done_retired", retired, 32'd2);

    // R-type mul opcode decode
    funct = 6'b011000;
    tick(); tick();
    check("mul_exec_op", alu_operation, 4'b0000);
    tick(); tick();
    check("mul_done_retired", retired, 32'd3);

    // beq taken: 0,1,8
    opcode = 6'b000100; zero_flag = 1'b1;
    tick();
    check("beq_decode_pc_en", pc_en, 1'b0);
    tick();
    check("beq_t_state", state, 4'd8);
    check("beq_t_pc_en", pc_en, 1'b1);
    check("beq_t_pc_source", pc_source, 2'b01);
    check("beq_t_alu_op", alu_operation, 4'b0110);
    zero_flag = 1'b0; #1;
    check("beq_zero_follow_pc_en", pc_en, 1'b0);
    tick();
    check("beq_t_done_state", state, 4'd0);
    check("beq_t_done_retired", retired, 32'd4);

    // beq not taken
    tick(); tick();
    check("beq_nt_state", state, 4'd8);
    check("beq_nt_pc_en", pc_en, 1'b0);
    tick();
    check("beq_nt_done_state", state, 4'd0);
    check("beq_nt_retired", retired, 32'd5);

    // FETCH stalled 3 cycles, then jump
    opcode = 6'b000010; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_state", state, 4'd0);
      check("stall_mem_read", mem_read, 1'b1);
      check("stall_ir_write", ir_write, 1'b0);
      check("stall_pc_en", pc_en, 1'b0);
      check("stall_src_b", alu_src_b, 2'b01);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("stall_end_state", state, 4'd0);
    check("stall_end_ir_write", ir_write, 1'b1);
    check("stall_end_pc_en", pc_en, 1'b1);
    tick(); tick();
    check("j_state", state, 4'd9);
    check("j_pc_en", pc_en, 1'b1);
    check("j_pc_source", pc_source, 2'b10);
    tick();
    check("j_done_state", state, 4'd0);
    check("j_done_retired", retired, 32'd6);

    // illegal opcode: 0,1 then FETCH
    opcode = 6'b111111;
    tick();
    check("ill_op_state", state, 4'd1);
    check("ill_op_pulse", illegal_op, 1'b1);
    tick();
    check("ill_op_next_state", state, 4'd0);
    check("ill_op_pulse_end", illegal_op, 1'b0);
    check("ill_op_retired", retired, 32'd6);

    // illegal funct on R-type
    opcode = 6'b000000; funct = 6'b000001;
    tick();
    check("ill_fn_pulse", illegal_op, 1'b1);
    tick();
    check("ill_fn_next_state", state, 4'd0);
    check("ill_fn_retired", retired, 32'd6);

    // sw with one stall cycle in MEM_WRITE: 0,1,2,5,5
    opcode = 6'b101011;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("sw_state", state, 4'd5);
    check("sw_mem_write", mem_write, 1'b1);
    check("sw_iord", iord, 1'b1);
    tick();
    check("sw_stall_state", state, 4'd5);
    check("sw_stall_retired", retired, 32'd6);
    mem_ready = 1'b1;
    tick();
    check("sw_done_state", state, 4'd0);
    check("sw_done_retired", retired, 32'd7);

    // addi: 0,1,10,11
    opcode = 6'b001000;
    tick(); tick();
    check("addi_exec_state", state, 4'd10);
    check("addi_exec_src_b", alu_src_b, 2'b10);
    check("addi_exec_op", alu_operation, 4'b0010);
    tick();
    check("addi_wb_state", state, 4'd11);
    check("addi_wb_reg_write", reg_write, 1'b1);
    check("addi_wb_reg_dst", reg_dst, 1'b0);
    tick();
    check("addi_done_retired", retired, 32'd8);

    // reset asserted mid-MEM_READ
    opcode = 6'b100011;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("abort_pre_state", state, 4'd3);
    reset = 1'b1; #1;
    check("abort_state", state, 4'd0);
    check("abort_mem_read", mem_read, 1'b0);
    check("abort_reg_write", reg_write, 1'b0);
    check("abort_pc_en", pc_en, 1'b0);
    check("abort_retired", retired, 32'd0);
    mem_ready = 1'b1;
    tick();
    check("abort_hold_state", state, 4'd0);
    check("abort_hold_ir_write", ir_write, 1'b0);
    reset = 1'b0; #1;
    check("rel_mem_read", mem_read, 1'b1);
    check("rel_src_b", alu_src_b, 2'b01);
    check("rel_alu_op", alu_operation, 4'b0010);
    tick();
    check("rel_decode_state", state, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
